// File: rtl/fir_interp_x2.sv
// fir_interp_x2 : interpolate-by-2 polyphase FIR built on one time-shared MAC.
// Every accepted 8-bit sample produces two filtered outputs: the even phase
// first, then the odd phase. The 8-tap prototype filter is symmetric,
// h = {C0,C1,C2,C3,C3,C2,C1,C0}.
//   even = C0*d0 + C2*d1 + C3*d2 + C1*d3
//   odd  = C1*d0 + C3*d1 + C2*d2 + C0*d3
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-low reset
//   x_in, in_valid     signed input sample and its valid
//   in_ready           high only in IDLE (forced low while in reset)
//   y_out, out_valid   registered signed result and its valid
//   out_ready          downstream accepts y_out
module fir_interp_x2 #(
  parameter int COEF_W    = 16,
  parameter int C0        = -1024,
  parameter int C1        = 2048,
  parameter int C2        = 5120,
  parameter int C3        = 10240,
  parameter int OUT_SHIFT = 14,
  parameter int OUT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       x_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] y_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PROD_W = 8 + COEF_W;
  // Two guard bits: four products of at most 8+COEF_W bits each cannot overflow.
  localparam int ACC_W  = 8 + COEF_W + 2;

  localparam logic signed [COEF_W-1:0] K0 = COEF_W'(C0);
  localparam logic signed [COEF_W-1:0] K1 = COEF_W'(C1);
  localparam logic signed [COEF_W-1:0] K2 = COEF_W'(C2);
  localparam logic signed [COEF_W-1:0] K3 = COEF_W'(C3);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 <<< (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 <<< (OUT_W-1)));

  typedef enum logic [2:0] {IDLE, MAC_EVEN, OUT_EVEN, MAC_ODD, OUT_ODD} state_t;

  state_t state, state_nxt;

  logic signed [7:0]        d [4];
  logic signed [ACC_W-1:0]  acc;
  logic [1:0]               cnt;

  logic signed [7:0]        dsel;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [OUT_W-1:0]         y_sat;

  logic hs_in, hs_out, mac_last;

  assign hs_in    = in_valid & in_ready;
  assign hs_out   = out_valid & out_ready;
  assign mac_last = (cnt == 2'd3);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (hs_in)    state_nxt = MAC_EVEN;
      MAC_EVEN: if (mac_last) state_nxt = OUT_EVEN;
      OUT_EVEN: if (hs_out)   state_nxt = MAC_ODD;
      MAC_ODD:  if (mac_last) state_nxt = OUT_ODD;
      OUT_ODD:  if (hs_out)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready = rst & (state == IDLE);
  end

  // Tap select: the odd phase walks the even coefficient list backwards.
  always_comb begin
    dsel = d[cnt];
    coef = '0;
    if (state == MAC_ODD) begin
      unique case (cnt)
        2'd0:    coef = K1;
        2'd1:    coef = K3;
        2'd2:    coef = K2;
        default: coef = K0;
      endcase
    end else begin
      unique case (cnt)
        2'd0:    coef = K0;
        2'd1:    coef = K2;
        2'd2:    coef = K3;
        default: coef = K1;
      endcase
    end
  end

  // MAC and output scaling; >>> floors toward -inf before clamping.
  always_comb begin
    prod    = dsel * coef;
    sum     = acc + ACC_W'(prod);
    shifted = sum >>> OUT_SHIFT;
    if (shifted > SAT_HI)      y_sat = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) y_sat = SAT_LO[OUT_W-1:0];
    else                       y_sat = shifted[OUT_W-1:0];
  end

  // Datapath: delay line, accumulator, tap counter, output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) d[i] <= '0;
      acc       <= '0;
      cnt       <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs_in) begin
            d[3] <= d[2];
            d[2] <= d[1];
            d[1] <= d[0];
            d[0] <= signed'(x_in);
            acc  <= '0;
            cnt  <= '0;
          end
        end
        MAC_EVEN, MAC_ODD: begin
          acc <= sum;
          cnt <= cnt + 2'd1;
          if (mac_last) begin
            y_out     <= y_sat;
            out_valid <= 1'b1;
          end
        end
        OUT_EVEN: begin
          if (hs_out) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        OUT_ODD: begin
          if (hs_out) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fir_interp_x2.md
Name: fir_interp_x2

Overview:
- Interpolate-by-2 polyphase FIR: accepts 8-bit signed samples at the input rate and emits two filtered samples per input (even phase, then odd phase).
- Sits on the rate-increase side of the filter chain, opposite the symmetric decimating/receive FIR path.
- Prototype filter is 8-tap symmetric: h = {C0,C1,C2,C3,C3,C2,C1,C0}.
- Uses one time-shared multiplier-accumulator with valid/ready handshakes on both sides.

Parameters:
- COEF_W, 16, signed coefficient width.
- C0, -1024, h[0]=h[7].
- C1, 2048, h[1]=h[6].
- C2, 5120, h[2]=h[5].
- C3, 10240, h[3]=h[4]. Defaults sum to 16384 = unity DC gain per phase at OUT_SHIFT=14.
- OUT_SHIFT, 14, arithmetic right shift applied to the accumulator.
- OUT_W, 10, output width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- x_in  in  8  signed input sample.
- in_valid  in  1  x_in valid.
- in_ready  out  1  block can accept a sample.
- y_out  out  OUT_W  signed output sample, registered.
- out_valid  out  1  y_out valid.
- out_ready  in  1  downstream accepts y_out.

Behaviour:
- Reset (rst=0, async): delay line d[0..3]=0, acc=0, tap counter=0, y_out=0, out_valid=0, state=IDLE.
- in_ready = (state==IDLE); it is combinational from state and 0 while rst=0.
- Delay line: on input handshake (in_valid & in_ready at an edge), shift d[3]<=d[2], d[2]<=d[1], d[1]<=d[0], d[0]<=x_in.
- The delay line shifts only on an input handshake, never otherwise.
- Even phase sum: C0*d0 + C2*d1 + C3*d2 + C1*d3.
- Odd phase sum: C1*d0 + C3*d1 + C2*d2 + C0*d3 (the even coefficient order reversed).
- FSM states: IDLE, MAC_EVEN, OUT_EVEN, MAC_ODD, OUT_ODD.
- IDLE: on input handshake, shift the line, clear acc and counter, go to MAC_EVEN.
- MAC_EVEN and MAC_ODD: one product per cycle, 4 cycles (counter 0..3), counter index selects d[k] and its phase coefficient.
  - On the 4th edge, y_out <= sat(acc+product), out_valid <= 1, next state OUT_*.
- OUT_EVEN: hold y_out and out_valid until out_valid & out_ready at an edge.
  - Then out_valid <= 0, clear acc and counter, go to MAC_ODD.
- OUT_ODD: on handshake, out_valid <= 0, go to IDLE.
- Latency: input accepted at edge T -> even y_out valid after edge T+4.
  - Odd y_out is valid 4 edges after the even handshake.
- Minimum spacing between input handshakes: 11 cycles, achieved with out_ready held at 1.
- Arithmetic:
  - Products are 8 x COEF_W signed.
  - acc is 8+COEF_W+2 bits signed (26 at defaults); it never overflows.
  - Result = acc >>> OUT_SHIFT (arithmetic shift, rounds toward -inf).
  - Result saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-512, 511] at defaults.
- Backpressure: y_out and out_valid remain stable while out_valid=1 and out_ready=0. in_valid is ignored outside IDLE.
- out_ready high while out_valid=0 has no effect.
- Reset mid-operation (any state): immediate return to reset values; a partial accumulation is discarded and no output is emitted.
- Simultaneous out handshake in OUT_ODD and in_valid=1: the input is not accepted that cycle (in_ready=0). It is accepted on the next edge in IDLE.

Test Plan:
- Impulse, defaults, out_ready=1: inputs 64,0,0,0 -> y_out sequence -4,8,20,40,40,20,8,-4; then zeros for further zero inputs.
- DC: 6 consecutive inputs of 100 -> from the 4th input onward, both phases output 100. Inputs -100 -> -100.
- Saturation, OUT_SHIFT=10: steady 127 -> 511 on both phases; steady -128 -> -512.
- Backpressure: hold out_ready=0 for 5 cycles in OUT_EVEN -> y_out and out_valid constant, in_ready=0, in_valid pulses ignored, delay line unchanged. Release -> odd output follows 4 edges later.
- Latency/throughput: in_valid held high with out_ready=1 -> in_ready pulses every 11 cycles; even output valid exactly 4 edges after acceptance.
- Reset: assert rst=0 during MAC_ODD -> out_valid=0 and y_out=0 immediately. After release, input 64 -> even output -4, proving the delay line was cleared.
